// File: rtl/bconv_engine.sv
// bconv_engine -- binary convolution engine.
//
// Reads a KxK binary kernel from the weight memory and an NxM binary image from
// the input SRAM. For every output row r (0..N-K) it evaluates output columns
// j = 0..M-K. Each output bit is a majority vote over the KxK window: it is 1
// when at least half of the (input XNOR weight) terms are 1. One result word is
// written per output row.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   dut_run / dut_busy      : start request (sampled in IDLE) / job in progress
//   dut_sram_read_address   : input SRAM address (data returns one cycle later)
//   sram_dut_read_data      : input SRAM data
//   dut_wmem_read_address   : weight memory address (data returns one cycle later)
//   wmem_dut_read_data      : weight memory data
//   dut_sram_write_*        : output SRAM write port (one word per output row)
//   err_dims                : last job was rejected for illegal dimensions
module bconv_engine #(
    parameter int KMAX = 5,
    parameter int W    = 16,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dut_run,
    output logic          dut_busy,
    output logic [AW-1:0] dut_sram_read_address,
    input  logic [W-1:0]  sram_dut_read_data,
    output logic [AW-1:0] dut_wmem_read_address,
    input  logic [W-1:0]  wmem_dut_read_data,
    output logic [AW-1:0] dut_sram_write_address,
    output logic [W-1:0]  dut_sram_write_data,
    output logic          dut_sram_write_enable,
    output logic          err_dims
);

    localparam int KW = 3;                              // holds any legal K (<= 7)
    localparam int MW = $clog2(KMAX*KMAX + 1) + 1;      // match counter width
    localparam int TW = MW + 1;                         // width for 2*match vs K*K
    localparam int CW = ((W > AW) ? W : AW) + 1;        // common width for dimension checks

    typedef enum logic [3:0] {
        IDLE, RD_K, RD_W, RD_DIM, CHECK, FILL, COL, WR, NEXT
    } state_t;

    state_t state_q, state_d;

    logic                     phase_q, phase_d;   // 0: address out, 1: data back
    logic [AW-1:0]            cnt_q, cnt_d;       // read index / output column
    logic [AW-1:0]            row_q, row_d;       // current output row r
    logic [AW-1:0]            n_q, n_d;
    logic [AW-1:0]            m_q, m_d;
    logic [W-1:0]             k_q, k_d;
    logic [KMAX-1:0][W-1:0]   rows_q, rows_d;     // [0] = newest row
    logic [KMAX-1:0][W-1:0]   wts_q, wts_d;       // [0] = last weight row read
    logic [W-1:0]             res_q, res_d;
    logic [AW-1:0]            raddr_q, raddr_d;
    logic [AW-1:0]            wmaddr_q, wmaddr_d;
    logic [AW-1:0]            waddr_q, waddr_d;
    logic [W-1:0]             wdata_q, wdata_d;
    logic                     we_q, we_d;
    logic                     err_q, err_d;

    logic [KW-1:0] k_s;
    logic [AW-1:0] k_aw;
    logic          illegal;
    logic          w_last;
    logic          last_row;
    logic [MW-1:0] match;
    logic          thr;
    logic [W-1:0]  col_bit;

    assign k_s  = k_q[KW-1:0];
    assign k_aw = AW'(k_s);

    assign illegal = (k_q == '0) || (CW'(k_q) > CW'(KMAX)) || (CW'(m_q) > CW'(W)) ||
                     (CW'(n_q) < CW'(k_q)) || (CW'(m_q) < CW'(k_q));

    // Weight rows are read until K rows are in (capped at KMAX so an illegal K
    // cannot run away); CHECK rejects the job afterwards if K was bad.
    assign w_last   = (CW'(cnt_q) + CW'(1) >= CW'(k_q)) || (cnt_q == AW'(KMAX-1));
    assign last_row = (row_q == n_q - k_aw);

    // Both buffers are shift registers filled in row order, so after K loads
    // kernel/window row i sits at index K-1-i in both; pairing index p with p
    // lines them up without any variable indexing.
    always_comb begin
        logic [W-1:0] win;
        match = '0;
        win   = '0;
        for (int p = 0; p < KMAX; p++) begin
            win = rows_q[p] >> cnt_q;
            for (int c = 0; c < KMAX; c++) begin
                if ((KW'(p) < k_s) && (KW'(c) < k_s) && (win[c] == wts_q[p][c]))
                    match = match + MW'(1);
            end
        end
        thr     = ({match, 1'b0} >= TW'(k_s) * TW'(k_s));
        col_bit = W'(thr) << cnt_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dut_run) state_d = RD_K;
            RD_K:    if (phase_q) state_d = RD_W;
            RD_W:    if (phase_q && w_last) state_d = RD_DIM;
            RD_DIM:  if (phase_q && cnt_q[0]) state_d = CHECK;
            CHECK:   state_d = illegal ? IDLE : FILL;
            FILL:    if (phase_q && (cnt_q == k_aw - AW'(1))) state_d = COL;
            COL:     if (cnt_q == m_q - k_aw) state_d = WR;
            // Going straight to IDLE after the final write drops busy one
            // cycle after the write enable.
            WR:      state_d = last_row ? IDLE : NEXT;
            NEXT:    if (phase_q) state_d = COL;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output logic
    always_comb begin
        phase_d  = 1'b0;
        cnt_d    = cnt_q;
        row_d    = row_q;
        n_d      = n_q;
        m_d      = m_q;
        k_d      = k_q;
        rows_d   = rows_q;
        wts_d    = wts_q;
        res_d    = res_q;
        raddr_d  = raddr_q;
        wmaddr_d = wmaddr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (dut_run) begin
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    row_d    = '0;
                    raddr_d  = '0;
                    wmaddr_d = '0;
                    waddr_d  = '0;
                end
            end
            RD_K: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    k_d      = wmem_dut_read_data;
                    wmaddr_d = AW'(1);
                    cnt_d    = '0;
                end
            end
            RD_W: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    wts_d[0] = wmem_dut_read_data;
                    for (int p = 1; p < KMAX; p++) wts_d[p] = wts_q[p-1];
                    if (w_last) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d    = cnt_q + AW'(1);
                        wmaddr_d = wmaddr_q + AW'(1);
                    end
                end
            end
            RD_DIM: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (!cnt_q[0]) begin
                        n_d     = AW'(sram_dut_read_data);
                        cnt_d   = AW'(1);
                        raddr_d = AW'(1);
                    end else begin
                        m_d   = AW'(sram_dut_read_data);
                        cnt_d = '0;
                    end
                end
            end
            CHECK: begin
                if (illegal) begin
                    err_d = 1'b1;
                end else begin
                    raddr_d = AW'(2);
                    cnt_d   = '0;
                end
            end
            FILL: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    rows_d[0] = sram_dut_read_data;
                    for (int p = 1; p < KMAX; p++) rows_d[p] = rows_q[p-1];
                    if (cnt_q == k_aw - AW'(1)) begin
                        cnt_d = '0;
                        res_d = '0;
                    end else begin
                        cnt_d   = cnt_q + AW'(1);
                        raddr_d = raddr_q + AW'(1);
                    end
                end
            end
            COL: begin
                res_d = res_q | col_bit;
                if (cnt_q == m_q - k_aw) begin
                    we_d    = 1'b1;
                    wdata_d = res_q | col_bit;
                    waddr_d = row_q;
                    // Pre-address the next input row (r+K) for NEXT.
                    raddr_d = row_q + k_aw + AW'(2);
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            NEXT: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    rows_d[0] = sram_dut_read_data;
                    for (int p = 1; p < KMAX; p++) rows_d[p] = rows_q[p-1];
                    row_d = row_q + AW'(1);
                    cnt_d = '0;
                    res_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            row_q    <= '0;
            n_q      <= '0;
            m_q      <= '0;
            k_q      <= '0;
            rows_q   <= '0;
            wts_q    <= '0;
            res_q    <= '0;
            raddr_q  <= '0;
            wmaddr_q <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            n_q      <= n_d;
            m_q      <= m_d;
            k_q      <= k_d;
            rows_q   <= rows_d;
            wts_q    <= wts_d;
            res_q    <= res_d;
            raddr_q  <= raddr_d;
            wmaddr_q <= wmaddr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    assign dut_busy               = (state_q != IDLE);
    assign dut_sram_read_address  = raddr_q;
    assign dut_wmem_read_address  = wmaddr_q;
    assign dut_sram_write_address = waddr_q;
    assign dut_sram_write_data    = wdata_q;
    assign dut_sram_write_enable  = we_q;
    assign err_dims               = err_q;

endmodule

// File: tb/tb_bconv_engine.sv
// Directed, table-driven bench for bconv_engine with behavioural memories.
module tb_bconv_engine;
    localparam int KMAX = 5;
    localparam int W    = 16;
    localparam int AW   = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dut_run = 1'b0;
    logic          dut_busy;
    logic [AW-1:0] dut_sram_read_address;
    logic [W-1:0]  sram_dut_read_data;
    logic [AW-1:0] dut_wmem_read_address;
    logic [W-1:0]  wmem_dut_read_data;
    logic [AW-1:0] dut_sram_write_address;
    logic [W-1:0]  dut_sram_write_data;
    logic          dut_sram_write_enable;
    logic          err_dims;

    bconv_engine #(.KMAX(KMAX), .W(W), .AW(AW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .dut_run                (dut_run),
        .dut_busy               (dut_busy),
        .dut_sram_read_address  (dut_sram_read_address),
        .sram_dut_read_data     (sram_dut_read_data),
        .dut_wmem_read_address  (dut_wmem_read_address),
        .wmem_dut_read_data     (wmem_dut_read_data),
        .dut_sram_write_address (dut_sram_write_address),
        .dut_sram_write_data    (dut_sram_write_data),
        .dut_sram_write_enable  (dut_sram_write_enable),
        .err_dims               (err_dims)
    );

    always #5 clk = ~clk;

    // Memories with one cycle of read latency
    logic [W-1:0] sram_mem [64];
    logic [W-1:0] wmem     [16];
    always @(posedge clk) begin
        sram_dut_read_data <= sram_mem[dut_sram_read_address[5:0]];
        wmem_dut_read_data <= wmem[dut_wmem_read_address[3:0]];
    end

    // Write capture and busy-fall timing, sampled on the falling edge
    int   cyc = 0;
    int   fall_cyc = 0;
    logic busy_prev = 1'b0;
    int   wq_a[$];
    int   wq_d[$];
    int   wq_c[$];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dut_sram_write_enable) begin
            wq_a.push_back(int'(dut_sram_write_address));
            wq_d.push_back(int'(dut_sram_write_data));
            wq_c.push_back(cyc);
        end
        if (busy_prev && !dut_busy) fall_cyc = cyc;
        busy_prev = dut_busy;
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    typedef struct packed {
        int               k;
        logic [4:0][15:0] w;
        int               n;
        int               m;
        logic [7:0][15:0] rows;
        bit               err;
        int               nw;
        logic [7:0][15:0] exp;
    } vec_t;

    function automatic vec_t mkv(input int k, input logic [15:0] w, input int n, input int m,
                                 input logic [15:0] r, input bit e, input int nw,
                                 input logic [15:0] x);
        vec_t v;
        v.k = k; v.n = n; v.m = m; v.err = e; v.nw = nw;
        for (int i = 0; i < 5; i++) v.w[i] = w;
        for (int i = 0; i < 8; i++) begin
            v.rows[i] = r;
            v.exp[i]  = x;
        end
        return v;
    endfunction

    task automatic load_mem(input vec_t v);
        for (int i = 0; i < 16; i++) wmem[i] = '0;
        for (int i = 0; i < 64; i++) sram_mem[i] = '0;
        wmem[0] = W'(v.k);
        for (int i = 0; i < 5; i++) wmem[1+i] = v.w[i];
        sram_mem[0] = W'(v.n);
        sram_mem[1] = W'(v.m);
        for (int i = 0; i < 8; i++) sram_mem[2+i] = v.rows[i];
    endtask

    task automatic check_rst_outs(input string tag);
        chk({tag, "_ctl"}, {29'd0, dut_busy, err_dims, dut_sram_write_enable}, 32'd0);
        chk({tag, "_raddr"}, {20'd0, dut_sram_read_address}, 32'd0);
        chk({tag, "_wmaddr"}, {20'd0, dut_wmem_read_address}, 32'd0);
        chk({tag, "_waddr"}, {20'd0, dut_sram_write_address}, 32'd0);
        chk({tag, "_wdata"}, {16'd0, dut_sram_write_data}, 32'd0);
    endtask

    // Starts at a falling edge; dut_run is held for three cycles so the
    // extra samples land in non-IDLE states and must be ignored.
    task automatic exec(input vec_t v, input int id);
        wq_a.delete(); wq_d.delete(); wq_c.delete();
        dut_run = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_busy_hi", id), {31'd0, dut_busy}, 32'd1);
        chk($sformatf("v%0d_err_clr", id), {31'd0, err_dims}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        dut_run = 1'b0;
        for (int t = 0; t < 3000 && dut_busy; t++) @(negedge clk);
        #1;
        chk($sformatf("v%0d_busy_done", id), {31'd0, dut_busy}, 32'd0);
        chk($sformatf("v%0d_err", id), {31'd0, err_dims}, {31'd0, v.err});
        chk($sformatf("v%0d_nwr", id), wq_a.size(), v.nw);
        for (int i = 0; i < wq_a.size() && i < 8; i++) begin
            chk($sformatf("v%0d_wr%0d_addr", id, i), wq_a[i], i);
            chk($sformatf("v%0d_wr%0d_data", id, i), wq_d[i], {16'd0, v.exp[i]});
        end
        if (wq_c.size() > 0)
            chk($sformatf("v%0d_busy_fall", id), fall_cyc, wq_c[wq_c.size()-1] + 1);
    endtask

    vec_t vecs[11];
    vec_t rv;

    initial begin
        vecs[0]  = mkv(1, 16'h0001, 2, 16, 16'h0000, 1'b0, 2, 16'h0000);
        vecs[0].rows[0] = 16'hA5A5; vecs[0].rows[1] = 16'h0F0F;
        vecs[0].exp[0]  = 16'hA5A5; vecs[0].exp[1]  = 16'h0F0F;
        vecs[1]  = mkv(3, 16'h0007, 4, 4, 16'h000F, 1'b0, 2, 16'h0003);
        vecs[2]  = mkv(3, 16'h0007, 3, 5, 16'h0000, 1'b0, 1, 16'h0000);
        vecs[3]  = mkv(5, 16'h001F, 5, 5, 16'h001F, 1'b0, 1, 16'h0001);
        vecs[3].rows[2] = 16'h0000;
        vecs[4]  = mkv(6, 16'h003F, 6, 6, 16'h003F, 1'b1, 0, 16'h0000);  // K > KMAX
        vecs[5]  = mkv(3, 16'h0007, 4, 17, 16'h0007, 1'b1, 0, 16'h0000); // M > W
        vecs[6]  = mkv(0, 16'h0000, 4, 4, 16'h0000, 1'b1, 0, 16'h0000);  // K = 0
        vecs[7]  = mkv(3, 16'h0007, 2, 4, 16'h0000, 1'b1, 0, 16'h0000);  // N < K
        // K=2, mixed kernel with junk above bit K-1; tie at match=2 counts as 1
        vecs[8]  = mkv(2, 16'h0000, 3, 4, 16'h0000, 1'b0, 2, 16'h0000);
        vecs[8].w[0] = 16'hFFF1; vecs[8].w[1] = 16'h00F2;
        vecs[8].rows[0] = 16'hF006; vecs[8].rows[1] = 16'h0009; vecs[8].rows[2] = 16'h0003;
        vecs[8].exp[0]  = 16'h0006; vecs[8].exp[1]  = 16'h0001;
        // K=3 threshold edge: match 5 -> 1, match 4 -> 0
        vecs[9]  = mkv(3, 16'h0007, 3, 3, 16'h0000, 1'b0, 1, 16'h0001);
        vecs[9].rows[0] = 16'h0007; vecs[9].rows[1] = 16'h0003;
        vecs[10] = mkv(3, 16'h0007, 3, 3, 16'h0000, 1'b0, 1, 16'h0000);
        vecs[10].rows[0] = 16'h0003; vecs[10].rows[1] = 16'h0003;

        rv = mkv(3, 16'h0007, 6, 8, 16'h00FF, 1'b0, 4, 16'h003F);

        for (int i = 0; i < 16; i++) wmem[i] = '0;
        for (int i = 0; i < 64; i++) sram_mem[i] = '0;

        repeat (3) @(negedge clk);
        check_rst_outs("por");
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            load_mem(vecs[v]);
            exec(vecs[v], v);
            @(negedge clk);
        end

        // Reset in the middle of COL, then restart immediately after release
        load_mem(rv);
        wq_a.delete(); wq_d.delete(); wq_c.delete();
        dut_run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dut_run = 1'b0;
        repeat (19) @(negedge clk);
        chk("abort_busy_before_rst", {31'd0, dut_busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_rst_outs("midrst");
        @(negedge clk);
        chk("abort_nwr", wq_a.size(), 0);
        reset = 1'b0;
        exec(rv, 11);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
